// File: rtl/exec_shift_alu_mem.sv
// Execute/memory stage: barrel shifter, ARM ALU, NZCV, F register, data RAM.
// Build macro MEM_RESET_CLEAR_EN: when defined, reset also clears the RAM.
module exec_shift_alu_mem #(
  parameter int MEM_ADDR_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] shift_data,
  input  logic [7:0]  shift_num,
  input  logic [2:0]  shift_op,
  input  logic [31:0] alu_a,
  input  logic [3:0]  alu_op,
  input  logic        s_en,
  input  logic        ld_f,
  input  logic        mem_write,
  input  logic [31:0] mem_wdata,
  output logic [31:0] shift_out,
  output logic        shift_cout,
  output logic [31:0] f_comb,
  output logic [31:0] f_reg,
  output logic [3:0]  nzcv,
  output logic [31:0] mem_rdata
);

  localparam int DEPTH = 2 ** MEM_ADDR_W;

  logic [4:0]  n5;
  logic        c_in;
  logic        d31;
  logic        big;
  logic        eq32;
  logic        zero8;
  logic        zero5;
  logic [32:0] lsl_w;
  logic [32:0] lsr_w;
  logic [32:0] asr_w;
  logic [63:0] ror_w;

  assign n5    = shift_num[4:0];
  assign c_in  = nzcv[1];
  assign d31   = shift_data[31];
  assign big   = |shift_num[7:5];
  assign eq32  = (shift_num == 8'd32);
  assign zero8 = (shift_num == 8'd0);
  assign zero5 = (n5 == 5'd0);

  // Carry falls out as the extra bit shifted past the word edge.
  assign lsl_w = {1'b0, shift_data} << n5;
  assign lsr_w = {shift_data, 1'b0} >> n5;
  assign asr_w = $unsigned($signed({shift_data, 1'b0}) >>> n5);
  assign ror_w = {shift_data, shift_data} >> n5;

  // Shifter: immediate forms reinterpret 0, register forms saturate at 32.
  always_comb begin
    shift_out  = shift_data;
    shift_cout = c_in;
    unique case (shift_op)
      3'b000: begin
        if (!zero5) begin
          shift_out  = lsl_w[31:0];
          shift_cout = lsl_w[32];
        end
      end
      3'b010: begin
        if (zero5) begin
          shift_out  = '0;
          shift_cout = d31;
        end else begin
          shift_out  = lsr_w[32:1];
          shift_cout = lsr_w[0];
        end
      end
      3'b100: begin
        if (zero5) begin
          shift_out  = {32{d31}};
          shift_cout = d31;
        end else begin
          shift_out  = asr_w[32:1];
          shift_cout = asr_w[0];
        end
      end
      3'b110: begin
        if (zero5) begin
          shift_out  = {c_in, shift_data[31:1]};
          shift_cout = shift_data[0];
        end else begin
          shift_out  = ror_w[31:0];
          shift_cout = ror_w[31];
        end
      end
      3'b001: begin
        if (!zero8) begin
          if (big) begin
            shift_out  = '0;
            shift_cout = eq32 & shift_data[0];
          end else begin
            shift_out  = lsl_w[31:0];
            shift_cout = lsl_w[32];
          end
        end
      end
      3'b011: begin
        if (!zero8) begin
          if (big) begin
            shift_out  = '0;
            shift_cout = eq32 & d31;
          end else begin
            shift_out  = lsr_w[32:1];
            shift_cout = lsr_w[0];
          end
        end
      end
      3'b101: begin
        if (!zero8) begin
          if (big) begin
            shift_out  = {32{d31}};
            shift_cout = d31;
          end else begin
            shift_out  = asr_w[32:1];
            shift_cout = asr_w[0];
          end
        end
      end
      3'b111: begin
        if (!zero8) begin
          shift_out  = ror_w[31:0];
          shift_cout = ror_w[31];
        end
      end
    endcase
  end

  logic [31:0] opx;
  logic [31:0] opy;
  logic        cin;
  logic        arith;
  logic [32:0] sum;
  logic        v_arith;

  // Adder operand select: subtraction is x + ~y + cin.
  always_comb begin
    opx   = alu_a;
    opy   = shift_out;
    cin   = 1'b0;
    arith = 1'b1;
    case (alu_op)
      4'h2, 4'hA: begin
        opy = ~shift_out;
        cin = 1'b1;
      end
      4'h3: begin
        opx = shift_out;
        opy = ~alu_a;
        cin = 1'b1;
      end
      4'h4, 4'hB: ;
      4'h5: cin = c_in;
      4'h6: begin
        opy = ~shift_out;
        cin = c_in;
      end
      4'h7: begin
        opx = shift_out;
        opy = ~alu_a;
        cin = c_in;
      end
      default: arith = 1'b0;
    endcase
  end

  assign sum     = {1'b0, opx} + {1'b0, opy} + {32'd0, cin};
  assign v_arith = (opx[31] == opy[31]) & (sum[31] != opx[31]);

  // Result mux: logical ops bypass the adder.
  always_comb begin
    f_comb = sum[31:0];
    case (alu_op)
      4'h0, 4'h8: f_comb = alu_a & shift_out;
      4'h1, 4'h9: f_comb = alu_a ^ shift_out;
      4'hC:       f_comb = alu_a | shift_out;
      4'hD:       f_comb = shift_out;
      4'hE:       f_comb = alu_a & ~shift_out;
      4'hF:       f_comb = ~shift_out;
      default:    ;
    endcase
  end

  logic [3:0] flags;

  assign flags = {f_comb[31],
                  f_comb == 32'd0,
                  arith ? sum[32] : shift_cout,
                  arith ? v_arith : nzcv[0]};

  // Flag and F registers load independently from the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_reg <= '0;
      nzcv  <= '0;
    end else begin
      if (ld_f) f_reg <= f_comb;
      if (s_en) nzcv  <= flags;
    end
  end

  logic [MEM_ADDR_W-1:0] idx;

  assign idx = f_reg[MEM_ADDR_W+1:2];

`ifdef MEM_RESET_CLEAR_EN
  logic [31:0] mem [DEPTH];

  // Data RAM, cleared by reset; writes use the pre-edge F address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_write) begin
      mem[idx] <= mem_wdata;
    end
  end
`else
  logic [31:0] mem [DEPTH] = '{default: '0};

  // Data RAM, untouched by reset; writes use the pre-edge F address.
  always_ff @(posedge clk) begin
    if (rst && mem_write) mem[idx] <= mem_wdata;
  end
`endif

  assign mem_rdata = mem[idx];

endmodule

// File: tb/tb_exec_shift_alu_mem.sv
// Bench for exec_shift_alu_mem: directed cases then random vectors
// checked against an arithmetic reference model.
module tb_exec_shift_alu_mem;

  localparam int AW = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] shift_data = '0;
  logic [7:0]  shift_num = '0;
  logic [2:0]  shift_op = '0;
  logic [31:0] alu_a = '0;
  logic [3:0]  alu_op = '0;
  logic        s_en = 1'b0;
  logic        ld_f = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] shift_out;
  logic        shift_cout;
  logic [31:0] f_comb;
  logic [31:0] f_reg;
  logic [3:0]  nzcv;
  logic [31:0] mem_rdata;

  exec_shift_alu_mem #(.MEM_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .shift_data(shift_data), .shift_num(shift_num),
    .shift_op(shift_op), .alu_a(alu_a), .alu_op(alu_op),
    .s_en(s_en), .ld_f(ld_f), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .shift_out(shift_out),
    .shift_cout(shift_cout), .f_comb(f_comb), .f_reg(f_reg),
    .nzcv(nzcv), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_f = '0;
  logic [3:0]  m_nzcv = '0;
  logic [31:0] m_mem [2**AW];
  logic [31:0] e_so;
  logic        e_sc;
  logic [31:0] e_fc;
  logic [3:0]  e_fl;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void ref_shift(input logic [31:0] d,
                                    input logic [7:0] n8,
                                    input logic [2:0] op,
                                    input logic c,
                                    output logic [31:0] o,
                                    output logic co);
    int n;
    int m;
    o  = d;
    co = c;
    if (!op[0]) begin
      n = int'(n8[4:0]);
      case (op[2:1])
        2'd0: if (n != 0) begin o = d << n; co = d[32-n]; end
        2'd1: if (n == 0) begin o = 0; co = d[31]; end
              else begin o = d >> n; co = d[n-1]; end
        2'd2: if (n == 0) begin o = {32{d[31]}}; co = d[31]; end
              else begin o = $signed(d) >>> n; co = d[n-1]; end
        default:
          if (n == 0) begin o = {c, d[31:1]}; co = d[0]; end
          else begin o = (d >> n) | (d << (32 - n)); co = d[n-1]; end
      endcase
    end else begin
      n = int'(n8);
      if (n != 0) begin
        case (op[2:1])
          2'd0: if (n < 32) begin o = d << n; co = d[32-n]; end
                else begin o = 0; co = (n == 32) ? d[0] : 1'b0; end
          2'd1: if (n < 32) begin o = d >> n; co = d[n-1]; end
                else begin o = 0; co = (n == 32) ? d[31] : 1'b0; end
          2'd2: if (n < 32) begin o = $signed(d) >>> n; co = d[n-1]; end
                else begin o = {32{d[31]}}; co = d[31]; end
          default: begin
            m = n % 32;
            if (m == 0) begin o = d; co = d[31]; end
            else begin o = (d >> m) | (d << (32 - m)); co = d[m-1]; end
          end
        endcase
      end
    end
  endfunction

  function automatic void arith(input logic [31:0] x, input logic [31:0] y,
                                input bit sub, input bit ci,
                                output logic [31:0] r, output logic co,
                                output logic v);
    longint ux;
    longint uy;
    longint sx;
    longint sy;
    longint ur;
    longint sr;
    longint bw;
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (sub) begin
      bw = ci ? 0 : 1;
      ur = ux - uy - bw;
      co = (ux >= uy + bw);
      sr = sx - sy - bw;
    end else begin
      ur = ux + uy + (ci ? 1 : 0);
      co = (ur > 64'sd4294967295);
      sr = sx + sy + (ci ? 1 : 0);
    end
    r = ur[31:0];
    v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
  endfunction

  function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] op, input logic [3:0] fl,
                                  input logic sc, output logic [31:0] r,
                                  output logic [3:0] nf);
    logic c;
    logic v;
    c = sc;
    v = fl[0];
    r = '0;
    case (op)
      4'h0, 4'h8: r = a & b;
      4'h1, 4'h9: r = a ^ b;
      4'hC:       r = a | b;
      4'hD:       r = b;
      4'hE:       r = a & ~b;
      4'hF:       r = ~b;
      4'h2, 4'hA: arith(a, b, 1, 1, r, c, v);
      4'h3:       arith(b, a, 1, 1, r, c, v);
      4'h4, 4'hB: arith(a, b, 0, 0, r, c, v);
      4'h5:       arith(a, b, 0, fl[1], r, c, v);
      4'h6:       arith(a, b, 1, fl[1], r, c, v);
      default:    arith(b, a, 1, fl[1], r, c, v);
    endcase
    nf = {r[31], r == 32'd0, c, v};
  endfunction

  task automatic drive(input logic [31:0] d, input logic [7:0] n,
                       input logic [2:0] op, input logic [31:0] a,
                       input logic [3:0] aop, input logic s,
                       input logic l, input logic w,
                       input logic [31:0] wd);
    shift_data = d;
    shift_num  = n;
    shift_op   = op;
    alu_a      = a;
    alu_op     = aop;
    s_en       = s;
    ld_f       = l;
    mem_write  = w;
    mem_wdata  = wd;
    #1;
    ref_shift(d, n, op, m_nzcv[1], e_so, e_sc);
    ref_alu(a, e_so, aop, m_nzcv, e_sc, e_fc, e_fl);
    chk("shift_out", shift_out, e_so);
    chk("shift_cout", {31'd0, shift_cout}, {31'd0, e_sc});
    chk("f_comb", f_comb, e_fc);
    chk("f_reg", f_reg, m_f);
    chk("nzcv", {28'd0, nzcv}, {28'd0, m_nzcv});
    chk("mem_rdata", mem_rdata, m_mem[m_f[AW+1:2]]);
  endtask

  task automatic step();
    @(posedge clk);
    if (mem_write) m_mem[m_f[AW+1:2]] = mem_wdata;
    if (s_en) m_nzcv = e_fl;
    if (ld_f) m_f = e_fc;
    @(negedge clk);
  endtask

  function automatic logic [7:0] pick_n();
    logic [7:0] tbl [7];
    tbl = '{8'd0, 8'd1, 8'd31, 8'd32, 8'd33, 8'd64, 8'd255};
    if ($urandom_range(0, 2) == 0) return tbl[$urandom_range(0, 6)];
    return 8'($urandom);
  endfunction

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    m_f    = '0;
    m_nzcv = '0;
`ifdef MEM_RESET_CLEAR_EN
    for (int i = 0; i < 2**AW; i++) m_mem[i] = '0;
`endif
    chk("rst_f_reg", f_reg, 32'd0);
    chk("rst_nzcv", {28'd0, nzcv}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) m_mem[i] = '0;
    #2;
    chk("por_f_reg", f_reg, 32'd0);
    chk("por_nzcv", {28'd0, nzcv}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    drive(32'h80000001, 8'd1, 3'b000, 0, 4'hD, 1, 0, 0, 0);
    chk("lsl1", shift_out, 32'h00000002);
    chk("lsl1_c", {31'd0, shift_cout}, 32'd1);
    step();
    chk("mov_nzcv", {28'd0, nzcv}, 32'b0010);
    drive(32'h80000001, 8'd0, 3'b000, 0, 4'hD, 0, 0, 0, 0);
    chk("lsl0", shift_out, 32'h80000001);
    chk("lsl0_c", {31'd0, shift_cout}, 32'd1);
    drive(32'h00000003, 8'd0, 3'b110, 0, 4'hD, 0, 0, 0, 0);
    chk("rrx", shift_out, 32'h80000001);
    chk("rrx_c", {31'd0, shift_cout}, 32'd1);
    drive(32'h80000000, 8'd0, 3'b100, 0, 4'hD, 0, 0, 0, 0);
    chk("asr32", shift_out, 32'hFFFFFFFF);
    chk("asr32_c", {31'd0, shift_cout}, 32'd1);
    drive(32'h80000000, 8'd32, 3'b011, 0, 4'hD, 0, 0, 0, 0);
    chk("lsr_r32", shift_out, 32'd0);
    chk("lsr_r32_c", {31'd0, shift_cout}, 32'd1);
    drive(32'h80000000, 8'd40, 3'b011, 0, 4'hD, 0, 0, 0, 0);
    chk("lsr_r40", shift_out, 32'd0);
    chk("lsr_r40_c", {31'd0, shift_cout}, 32'd0);
    drive(32'h80000000, 8'd64, 3'b111, 0, 4'hD, 0, 0, 0, 0);
    chk("ror_r64", shift_out, 32'h80000000);
    chk("ror_r64_c", {31'd0, shift_cout}, 32'd1);

    drive(32'd5, 8'd0, 3'b000, 32'd5, 4'hA, 1, 0, 0, 0);
    step();
    chk("cmp_nzcv", {28'd0, nzcv}, 32'b0110);
    drive(32'd1, 8'd0, 3'b000, 32'h7FFFFFFF, 4'h4, 1, 0, 0, 0);
    chk("add_ovf", f_comb, 32'h80000000);
    step();
    chk("add_nzcv", {28'd0, nzcv}, 32'b1001);
    drive(32'd1, 8'd0, 3'b000, 32'd0, 4'h2, 1, 0, 0, 0);
    step();
    chk("sub_nzcv", {28'd0, nzcv}, 32'b1000);

    drive(32'h10, 8'd0, 3'b000, 0, 4'hD, 0, 1, 0, 0);
    step();
    chk("ld_f", f_reg, 32'h10);
    drive(32'h10, 8'd0, 3'b000, 0, 4'hD, 0, 0, 1, 32'hDEADBEEF);
    step();
    drive(32'h110, 8'd0, 3'b000, 0, 4'hD, 0, 1, 0, 0);
    chk("mem_rd", mem_rdata, 32'hDEADBEEF);
    step();
    drive(32'h0, 8'd0, 3'b000, 0, 4'hD, 0, 0, 0, 0);
    chk("mem_alias", mem_rdata, 32'hDEADBEEF);

    drive(32'h10, 8'd0, 3'b000, 0, 4'hD, 1, 1, 1, 32'h12345678);
    do_reset();
    drive(32'h10, 8'd0, 3'b000, 0, 4'hD, 0, 1, 0, 0);
    step();
    drive(32'h0, 8'd0, 3'b000, 0, 4'hD, 0, 0, 0, 0);
`ifdef MEM_RESET_CLEAR_EN
    chk("mem_after_rst", mem_rdata, 32'd0);
`else
    chk("mem_after_rst", mem_rdata, 32'hDEADBEEF);
`endif

    for (int k = 0; k < 600; k++) begin
      drive($urandom, pick_n(), 3'($urandom), $urandom, 4'($urandom),
            1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
            $urandom);
      step();
      if (k == 300) begin
        drive($urandom, pick_n(), 3'($urandom), $urandom, 4'($urandom),
              1, 1, 1, $urandom);
        do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
